// File: rtl/zone_input_states_if.sv
// rtl/zone_input_states_if.sv - switch inputs and zone status outputs of zone_input_states
interface zone_input_states_if #(
    parameter int NUM_ZONES = 4
) ();
    localparam int AW = $clog2(NUM_ZONES + 1);

    logic [NUM_ZONES-1:0] i_Switch;
    logic                 i_Clear_All;
    logic [NUM_ZONES-1:0] o_zone_states;
    logic [NUM_ZONES-1:0] o_zone_leds;
    logic                 o_change_pulse;
    logic [NUM_ZONES-1:0] o_change_mask;
    logic [AW-1:0]        o_active_count;

    modport slave (
        input  i_Switch,
        input  i_Clear_All,
        output o_zone_states,
        output o_zone_leds,
        output o_change_pulse,
        output o_change_mask,
        output o_active_count
    );

    modport master (
        output i_Switch,
        output i_Clear_All,
        input  o_zone_states,
        input  o_zone_leds,
        input  o_change_pulse,
        input  o_change_mask,
        input  o_active_count
    );
endinterface

// File: rtl/zone_input_states.sv
// rtl/zone_input_states.sv - debounced per-zone switch states with toggle/follow mode and change reporting
module zone_input_states #(
    parameter int NUM_ZONES       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TOGGLE_MODE     = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    zone_input_states_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(NUM_ZONES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ZONES-1:0] r_sync1;
    logic [NUM_ZONES-1:0] r_sync2;
    logic [NUM_ZONES-1:0] r_deb;
    logic [NUM_ZONES-1:0] r_deb_chg;
    logic [CW-1:0]        r_cnt [NUM_ZONES];
    logic [NUM_ZONES-1:0] r_state;
    logic [NUM_ZONES-1:0] r_mask;
    logic                 r_pulse;
    logic [AW-1:0]        r_count;

    logic [NUM_ZONES-1:0] w_next;
    logic [NUM_ZONES-1:0] w_diff;
    logic [AW-1:0]        w_next_count;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.i_Switch;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; reaching DEBOUNCE_CYCLES-1 on a disagreeing edge means
    // this is the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_deb     <= '0;
            r_deb_chg <= '0;
            for (int k = 0; k < NUM_ZONES; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_ZONES; k++) begin
                r_deb_chg[k] <= 1'b0;
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    r_deb[k]     <= r_sync2[k];
                    r_deb_chg[k] <= 1'b1;
                    r_cnt[k]     <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.i_Clear_All) begin
            w_next = '0;
        end else if (TOGGLE_MODE != 0) begin
            w_next = r_state ^ (r_deb_chg & r_deb);
        end else begin
            w_next = (r_state & ~r_deb_chg) | (r_deb & r_deb_chg);
        end
        w_diff = w_next ^ r_state;
        w_next_count = '0;
        for (int k = 0; k < NUM_ZONES; k++) begin
            w_next_count = w_next_count + AW'(w_next[k]);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= '0;
            r_mask  <= '0;
            r_pulse <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_mask  <= w_diff;
            r_pulse <= |w_diff;
            r_count <= w_next_count;
        end
    end

    assign bus.o_zone_states  = r_state;
    assign bus.o_zone_leds    = r_state;
    assign bus.o_change_pulse = r_pulse;
    assign bus.o_change_mask  = r_mask;
    assign bus.o_active_count = r_count;
endmodule

// File: doc/zone_input_states.md
ZONE_INPUT_STATES -- requirements
Module: zone_input_states

Interface
REQ-001 SHALL have parameter NUM_ZONES, default 4, number of independent switch inputs (range 1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a new switch level (range 1..2^20).
REQ-003 SHALL have parameter TOGGLE_MODE, default 1; 1 = each accepted press toggles the zone state, 0 = zone state follows the debounced level.
REQ-004 SHALL have port i_Clk, input, 1, single clock; all state is updated on its rising edge.
REQ-005 SHALL have port i_Reset_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port i_Switch, input, NUM_ZONES, raw asynchronous switch levels; bit k is zone k.
REQ-007 SHALL have port i_Clear_All, input, 1, synchronous request to force all zone states to 0.
REQ-008 SHALL have port o_zone_states, output, NUM_ZONES, registered zone state vector.
REQ-009 SHALL have port o_zone_leds, output, NUM_ZONES, LED drive equal to o_zone_states.
REQ-010 SHALL have port o_change_pulse, output, 1, one-cycle strobe when any zone state changes.
REQ-011 SHALL have port o_change_mask, output, NUM_ZONES, bits that changed on the cycle o_change_pulse is high, 0 otherwise.
REQ-012 SHALL have port o_active_count, output, $clog2(NUM_ZONES+1), number of set bits in o_zone_states.

Function
REQ-013 SHALL pass each i_Switch bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL keep one debounce counter per zone, cleared whenever the synchronized level equals that zone's debounced level.
REQ-015 SHALL update a zone's debounced level on the edge where its synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles, then clear the counter.
REQ-016 SHALL saturate nothing: counter width is $clog2(DEBOUNCE_CYCLES+1) and never exceeds DEBOUNCE_CYCLES.
REQ-017 SHALL, with TOGGLE_MODE=1, invert a zone state one edge after its debounced level rises 0->1; a debounced 1->0 transition has no effect.
REQ-018 SHALL, with TOGGLE_MODE=0, load the zone state from the debounced level one edge after it changes.
REQ-019 SHALL give total latency from the first i_Clk edge that samples a new stable input level to the zone state update of DEBOUNCE_CYCLES+2 edges.
REQ-020 SHALL clear all zone states at the next edge when i_Clear_All=1, taking priority over any coincident toggle/load event on any zone.
REQ-021 SHALL leave synchronizers, debounce counters and debounced levels unaffected by i_Clear_All.
REQ-022 SHALL assert o_change_pulse and o_change_mask on the same edge the zone state register changes, for exactly one cycle, with o_change_mask = old XOR new state.
REQ-023 SHALL not pulse o_change_pulse when i_Clear_All is asserted while all zone states are already 0.
REQ-024 SHALL handle simultaneous events on multiple zones in the same cycle, reporting all in one o_change_mask.
REQ-025 SHALL register o_active_count, valid on the same edge as o_zone_states.

Reset
REQ-026 SHALL, while i_Reset_n=0, drive o_zone_states=0, o_zone_leds=0, o_change_pulse=0, o_change_mask=0, o_active_count=0, and clear synchronizers, counters and debounced levels to 0.
REQ-027 SHALL take effect immediately on i_Reset_n falling, mid-debounce or mid-toggle, discarding in-progress counts.
REQ-028 SHALL generate no change pulse on the first edges after i_Reset_n rises while i_Switch=0.

Verification (NUM_ZONES=4, DEBOUNCE_CYCLES=4 unless noted)
REQ-029 SHALL test: i_Switch[0] held 1 for 20 cycles, TOGGLE_MODE=1 -> o_zone_states=4'b0001 exactly 6 edges after first sampling edge, o_change_pulse one cycle, mask 4'b0001, count 1; release then second press -> states 4'b0000, count 0.
REQ-030 SHALL test: i_Switch[1] glitches high for 3 cycles, then low -> no state change, no pulse.
REQ-031 SHALL test: i_Switch[2] and [3] pressed on same cycle -> states 4'b1100, single pulse, mask 4'b1100, count 2.
REQ-032 SHALL test: states 4'b1011, i_Clear_All pulsed on same cycle as zone 2 toggle event -> states 4'b0000, mask 4'b1011; i_Clear_All again -> no pulse.
REQ-033 SHALL test: TOGGLE_MODE=0, i_Switch=4'b0101 held -> states 4'b0101 after 6 edges; i_Switch=0 held -> states 4'b0000 after 6 edges.
REQ-034 SHALL test: i_Reset_n asserted 2 cycles into a debounce with states 4'b0001 -> all outputs 0 immediately; after release with i_Switch[0] still 1, toggle completes 6 edges later with mask 4'b0001.
